cell_addr_sequencer: RTL

CELL_ADDR_SEQUENCER -- requirements
Module: cell_addr_sequencer

---
 rtl/cell_addr_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cell_addr_sequencer.sv
`default_nettype none
// cell_addr_sequencer: raster-order pixel address walker over a window of image cells.
// Define CELL_ADDR_LAST_EN to add the oLastPix / oLastCell end-of-cell and end-of-run markers.
module cell_addr_sequencer #(
  parameter int CELL_W     = 8,
  parameter int CELL_H     = 8,
  parameter int CELLS_X    = 8,
  parameter int CELLS_Y    = 16,
  parameter int IMG_STRIDE = 66,
  parameter int ADDR_W     = 14,
  parameter int IDX_W      = 7
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iStart,
  input  logic [IDX_W-1:0]  iStartIdx,
  input  logic              iSingle,
  input  logic              iAbort,
  output logic              oAddrValid,
  input  logic              iAddrReady,
  output logic [ADDR_W-1:0] oAddr,
  output logic [IDX_W-1:0]  oCellIdx,
  output logic [ADDR_W-1:0] oBeginRow,
  output logic [ADDR_W-1:0] oBeginCol,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
`ifdef CELL_ADDR_LAST_EN
  ,
  output logic              oLastPix,
  output logic              oLastCell
`endif
);

  localparam int TOTAL = CELLS_X * CELLS_Y;
  localparam int PX_W  = (CELL_W  > 1) ? $clog2(CELL_W)  : 1;
  localparam int PY_W  = (CELL_H  > 1) ? $clog2(CELL_H)  : 1;
  localparam int CX_W  = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;

  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(CELL_H * IMG_STRIDE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_STRIDE);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(CELL_W);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(CELL_W - 1);
  localparam logic [PY_W-1:0]   PY_LAST   = PY_W'(CELL_H - 1);
  localparam logic [CX_W-1:0]   CX_LAST   = CX_W'(CELLS_X - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [PX_W-1:0]   px;
  logic [PY_W-1:0]   py;
  logic [CX_W-1:0]   cx;
  logic [ADDR_W-1:0] line_base;
  logic              single;

  logic              start_req, start_ok, fire, cell_end, run_end;
  logic [ADDR_W-1:0] start_row, start_col, next_row, next_col, next_base;
  logic [CX_W-1:0]   start_cx, next_cx;

  assign start_req = (state == S_IDLE) && iStart;
  assign fire      = (state == S_RUN) && iAddrReady;
  assign cell_end  = fire && (px == PX_LAST) && (py == PY_LAST);
  assign run_end   = cell_end && (single || (oCellIdx == IDX_LAST));

  // Start-cell bases come from an elaboration-time constant table, so no
  // runtime divide/multiply is needed for an arbitrary start index.
  always_comb begin
    start_ok  = 1'b0;
    start_row = '0;
    start_col = '0;
    start_cx  = '0;
    for (int i = 0; i < TOTAL; i++) begin
      if (int'(iStartIdx) == i) begin
        start_ok  = 1'b1;
        start_row = ADDR_W'((i / CELLS_X) * CELL_H * IMG_STRIDE);
        start_col = ADDR_W'((i % CELLS_X) * CELL_W);
        start_cx  = CX_W'(i % CELLS_X);
      end
    end
  end

  always_comb begin
    next_row = oBeginRow;
    next_col = oBeginCol + COL_STEP;
    next_cx  = cx + CX_W'(1);
    if (cx == CX_LAST) begin
      next_row = oBeginRow + ROW_STEP;
      next_col = '0;
      next_cx  = '0;
    end
  end

  assign next_base = next_row + next_col;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    oAddrValid = 1'b0;
    oBusy      = 1'b0;
    oDone      = 1'b0;
    case (state)
      S_IDLE: if (start_req && start_ok) state_nxt = S_RUN;
      S_RUN: begin
        oAddrValid = 1'b1;
        oBusy      = 1'b1;
        if (iAbort)       state_nxt = S_IDLE;
        else if (run_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        oDone     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oErr      <= 1'b0;
      oAddr     <= '0;
      oCellIdx  <= '0;
      oBeginRow <= '0;
      oBeginCol <= '0;
      line_base <= '0;
      px        <= '0;
      py        <= '0;
      cx        <= '0;
      single    <= 1'b0;
    end else begin
      oErr <= start_req && !start_ok;
      if (start_req && start_ok) begin
        oCellIdx  <= iStartIdx;
        oBeginRow <= start_row;
        oBeginCol <= start_col;
        cx        <= start_cx;
        px        <= '0;
        py        <= '0;
        line_base <= start_row + start_col;
        oAddr     <= start_row + start_col;
        single    <= iSingle;
      end else if (fire && !run_end) begin
        if (px != PX_LAST) begin
          px    <= px + PX_W'(1);
          oAddr <= oAddr + ADDR_ONE;
        end else if (py != PY_LAST) begin
          px        <= '0;
          py        <= py + PY_W'(1);
          line_base <= line_base + LINE_STEP;
          oAddr     <= line_base + LINE_STEP;
        end else begin
          px        <= '0;
          py        <= '0;
          cx        <= next_cx;
          oCellIdx  <= oCellIdx + IDX_W'(1);
          oBeginRow <= next_row;
          oBeginCol <= next_col;
          line_base <= next_base;
          oAddr     <= next_base;
        end
      end
    end
  end

`ifdef CELL_ADDR_LAST_EN
  assign oLastPix  = oAddrValid && (px == PX_LAST) && (py == PY_LAST);
  assign oLastCell = oLastPix && (single || (oCellIdx == IDX_LAST));
`endif

endmodule
`default_nettype wire
